// File: rtl/dmem_port_arbiter_pkg.sv
// ============================================================================
// dmem_port_arbiter_pkg : arbiter state encodings, lane ids, request decode
// Revision: 1.0
// ============================================================================
`default_nettype none

package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SECOND  = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_e;

    typedef struct packed {
        logic valid;
        logic store;
    } lane_op_t;

    // A lane asserting both read and write is treated as a store only.
    function automatic lane_op_t decode_req(input logic rd, input logic wr);
        lane_op_t op;
        op.valid = rd | wr;
        op.store = wr;
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_port_arbiter_sat_counter32.sv
// ============================================================================
// sat_counter32 : 32-bit event counter, saturating, sync active-low clear
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter32 (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        en,
    output logic [31:0] count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// dmem_port_arbiter : serialises two MEM-stage lanes onto one dmem port.
// Optional perf counters with DMEM_ARB_PERF_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          l0_mem_read,
    input  logic          l0_mem_write,
    input  logic [AW-1:0] l0_addr,
    input  logic [DW-1:0] l0_wdata,
    output logic [DW-1:0] l0_rdata,
    input  logic          l1_mem_read,
    input  logic          l1_mem_write,
    input  logic [AW-1:0] l1_addr,
    input  logic [DW-1:0] l1_wdata,
    output logic [DW-1:0] l1_rdata,
    output logic          mem_stall,
    output logic          dm_read,
    output logic          dm_write,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    input  logic [DW-1:0] dm_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]   perf_conflicts,
    output logic [31:0]   perf_stall_cycles
`endif
);

    lane_op_t   op0;
    lane_op_t   op1;

    arb_state_e state_q,     state_d;
    lane_e      last_lane_q, last_lane_d;
    logic       last_load_q, last_load_d;
    logic       l0_load_q,   l0_load_d;
    logic [DW-1:0] r0_q, r0_d;
    logic [DW-1:0] r1_q, r1_d;

    logic issue0;
    logic issue1;
    logic bypass0;
    logic bypass1;

    assign op0 = decode_req(l0_mem_read, l0_mem_write);
    assign op1 = decode_req(l1_mem_read, l1_mem_write);

    always_comb begin
        state_d     = state_q;
        last_lane_d = last_lane_q;
        last_load_d = last_load_q;
        l0_load_d   = l0_load_q;
        r0_d        = r0_q;
        r1_d        = r1_q;
        mem_stall   = 1'b0;
        issue0      = 1'b0;
        issue1      = 1'b0;
        bypass0     = 1'b0;
        bypass1     = 1'b0;
        dm_read     = 1'b0;
        dm_write    = 1'b0;
        dm_addr     = '0;
        dm_wdata    = '0;

        // Gating on rst_n keeps a reset cycle from strobing an abandoned request.
        if (rst_n) begin
            case (state_q)
                ARB_IDLE: begin
                    if (op0.valid && op1.valid) begin
                        issue0    = 1'b1;
                        mem_stall = 1'b1;
                        l0_load_d = ~op0.store;
                        state_d   = ARB_SECOND;
                    end else if (op0.valid) begin
                        issue0 = 1'b1;
                        if (!op0.store) begin
                            mem_stall   = 1'b1;
                            last_lane_d = LANE0;
                            last_load_d = 1'b1;
                            state_d     = ARB_RELEASE;
                        end
                    end else if (op1.valid) begin
                        issue1 = 1'b1;
                        if (!op1.store) begin
                            mem_stall   = 1'b1;
                            last_lane_d = LANE1;
                            last_load_d = 1'b1;
                            state_d     = ARB_RELEASE;
                        end
                    end
                end
                ARB_SECOND: begin
                    issue1      = 1'b1;
                    mem_stall   = 1'b1;
                    if (l0_load_q) begin
                        r0_d = dm_rdata;
                    end
                    last_lane_d = LANE1;
                    last_load_d = op1.valid & ~op1.store;
                    state_d     = ARB_RELEASE;
                end
                ARB_RELEASE: begin
                    if (last_load_q) begin
                        if (last_lane_q == LANE0) begin
                            bypass0 = 1'b1;
                            r0_d    = dm_rdata;
                        end else begin
                            bypass1 = 1'b1;
                            r1_d    = dm_rdata;
                        end
                    end
                    state_d = ARB_IDLE;
                end
                default: begin
                    state_d = ARB_IDLE;
                end
            endcase
        end

        if (issue0) begin
            dm_read  = op0.valid & ~op0.store;
            dm_write = op0.store;
            dm_addr  = l0_addr;
            dm_wdata = op0.store ? l0_wdata : '0;
        end else if (issue1) begin
            dm_read  = op1.valid & ~op1.store;
            dm_write = op1.store;
            dm_addr  = l1_addr;
            dm_wdata = op1.store ? l1_wdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            last_lane_q <= LANE0;
            last_load_q <= 1'b0;
            l0_load_q   <= 1'b0;
            r0_q        <= '0;
            r1_q        <= '0;
        end else begin
            state_q     <= state_d;
            last_lane_q <= last_lane_d;
            last_load_q <= last_load_d;
            l0_load_q   <= l0_load_d;
            r0_q        <= r0_d;
            r1_q        <= r1_d;
        end
    end

    assign l0_rdata = bypass0 ? dm_rdata : r0_q;
    assign l1_rdata = bypass1 ? dm_rdata : r1_q;

`ifdef DMEM_ARB_PERF_EN
    logic conflict_evt;

    assign conflict_evt = rst_n && (state_q == ARB_IDLE) && op0.valid && op1.valid;

    sat_counter32 u_perf_conflicts (
        .clk   (clk),
        .clr_n (rst_n),
        .en    (conflict_evt),
        .count (perf_conflicts)
    );

    sat_counter32 u_perf_stall_cycles (
        .clk   (clk),
        .clr_n (rst_n),
        .en    (mem_stall),
        .count (perf_stall_cycles)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
// tb_dmem_port_arbiter : directed + random transactions vs. a program-order model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        l0_mem_read, l0_mem_write;
    logic [63:0] l0_addr, l0_wdata, l0_rdata;
    logic        l1_mem_read, l1_mem_write;
    logic [63:0] l1_addr, l1_wdata, l1_rdata;
    logic        mem_stall, dm_read, dm_write;
    logic [63:0] dm_addr, dm_wdata, dm_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_conflicts, perf_stall_cycles;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    logic [63:0] mem     [0:255];
    logic [63:0] ref_mem [0:255];
    logic [63:0] exp_r0, exp_r1;

    dmem_port_arbiter #(.AW(64), .DW(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .l0_mem_read  (l0_mem_read),
        .l0_mem_write (l0_mem_write),
        .l0_addr      (l0_addr),
        .l0_wdata     (l0_wdata),
        .l0_rdata     (l0_rdata),
        .l1_mem_read  (l1_mem_read),
        .l1_mem_write (l1_mem_write),
        .l1_addr      (l1_addr),
        .l1_wdata     (l1_wdata),
        .l1_rdata     (l1_rdata),
        .mem_stall    (mem_stall),
        .dm_read      (dm_read),
        .dm_write     (dm_write),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_conflicts    (perf_conflicts),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory: read data appears the cycle after dm_read.
    always @(posedge clk) begin
        if (dm_write) mem[dm_addr[10:3]] = dm_wdata;
        if (dm_read)  dm_rdata = mem[dm_addr[10:3]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [63:0] a, input logic [63:0] d);
        mem[a[10:3]]     = d;
        ref_mem[a[10:3]] = d;
    endtask

    task automatic check_idle_port(input string tag);
        check({tag, "_stall"}, {63'd0, mem_stall}, 64'd0);
        check({tag, "_rd"},    {63'd0, dm_read},   64'd0);
        check({tag, "_wr"},    {63'd0, dm_write},  64'd0);
    endtask

    // op bits: [1]=write, [0]=read. Called just after a posedge; returns just after one.
    task automatic run_txn(input string tag,
                           input logic [1:0] op0, input logic [63:0] a0, input logic [63:0] d0,
                           input logic [1:0] op1, input logic [63:0] a1, input logic [63:0] d1);
        logic        v0, v1, st0, st1, ld0, ld1;
        logic [63:0] new0, new1;
        logic        iss_rd [2];
        logic        iss_wr [2];
        logic [63:0] iss_a  [2];
        logic [63:0] iss_d  [2];
        int          n_iss, n_stall, n_cyc;

        v0 = |op0; st0 = op0[1]; ld0 = v0 & ~st0;
        v1 = |op1; st1 = op1[1]; ld1 = v1 & ~st1;
        new0 = exp_r0; new1 = exp_r1;
        n_iss = 0;
        if (v0) begin
            iss_rd[n_iss] = ld0; iss_wr[n_iss] = st0; iss_a[n_iss] = a0; iss_d[n_iss] = d0;
            n_iss++;
            if (st0) ref_mem[a0[10:3]] = d0; else new0 = ref_mem[a0[10:3]];
        end
        if (v1) begin
            iss_rd[n_iss] = ld1; iss_wr[n_iss] = st1; iss_a[n_iss] = a1; iss_d[n_iss] = d1;
            n_iss++;
            if (st1) ref_mem[a1[10:3]] = d1; else new1 = ref_mem[a1[10:3]];
        end
        n_stall = (v0 && v1) ? 2 : ((ld0 || ld1) ? 1 : 0);
        n_cyc   = n_stall + 1;

        l0_mem_read = op0[0]; l0_mem_write = op0[1]; l0_addr = a0; l0_wdata = d0;
        l1_mem_read = op1[0]; l1_mem_write = op1[1]; l1_addr = a1; l1_wdata = d1;

        for (int k = 0; k < n_cyc; k++) begin
            @(negedge clk);
            check({tag, "_stall"}, {63'd0, mem_stall}, (k < n_stall) ? 64'd1 : 64'd0);
            if (k < n_iss) begin
                check({tag, "_rd"},   {63'd0, dm_read},  {63'd0, iss_rd[k]});
                check({tag, "_wr"},   {63'd0, dm_write}, {63'd0, iss_wr[k]});
                check({tag, "_addr"}, dm_addr, iss_a[k]);
                if (iss_wr[k]) check({tag, "_wdata"}, dm_wdata, iss_d[k]);
            end else begin
                check({tag, "_rd"}, {63'd0, dm_read},  64'd0);
                check({tag, "_wr"}, {63'd0, dm_write}, 64'd0);
            end
            check({tag, "_l0_rdata"}, l0_rdata, (ld0 && k == n_cyc - 1) ? new0 : exp_r0);
            check({tag, "_l1_rdata"}, l1_rdata, (ld1 && k == n_cyc - 1) ? new1 : exp_r1);
            @(posedge clk); #1;
        end
        exp_r0 = new0;
        exp_r1 = new1;
    endtask

    task automatic go_idle();
        l0_mem_read = 1'b0; l0_mem_write = 1'b0; l0_addr = '0; l0_wdata = '0;
        l1_mem_read = 1'b0; l1_mem_write = 1'b0; l1_addr = '0; l1_wdata = '0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 64'd0;
            ref_mem[i] = 64'd0;
        end
        dm_rdata = 64'd0;
        exp_r0 = 64'd0;
        exp_r1 = 64'd0;
        go_idle();
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_idle_port("reset");
        check("reset_addr",  dm_addr,  64'd0);
        check("reset_wdata", dm_wdata, 64'd0);
        check("reset_r0",    l0_rdata, 64'd0);
        check("reset_r1",    l1_rdata, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed scenarios
        preload(64'h100, 64'hAA);
        run_txn("t1_load", 2'b01, 64'h100, 64'h0, 2'b00, 64'h0, 64'h0);
        go_idle();
        @(negedge clk);
        check("t1_hold", l0_rdata, 64'hAA);
        @(posedge clk); #1;

        run_txn("t2_stst",  2'b10, 64'h200, 64'h11, 2'b10, 64'h200, 64'h22);
        run_txn("t2_read",  2'b00, 64'h0, 64'h0,    2'b01, 64'h200, 64'h0);
        run_txn("t3_stld",  2'b10, 64'h300, 64'h55, 2'b01, 64'h300, 64'h0);
        preload(64'h10, 64'd1);
        preload(64'h18, 64'd2);
        run_txn("t4_ldld",  2'b01, 64'h10, 64'h0,   2'b01, 64'h18, 64'h0);
        run_txn("wr_wins",  2'b11, 64'h308, 64'h77, 2'b00, 64'h0, 64'h0);
        run_txn("rd_back",  2'b01, 64'h308, 64'h0,  2'b00, 64'h0, 64'h0);

        // Reset while the second request of a pair is pending
        l0_mem_read = 1'b1; l0_addr = 64'h10;
        l1_mem_read = 1'b1; l1_addr = 64'h18;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_port("t5_in_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        go_idle();
        exp_r0 = 64'd0;
        exp_r1 = 64'd0;
        @(negedge clk);
        check_idle_port("t5_after");
        check("t5_r0", l0_rdata, 64'd0);
        check("t5_r1", l1_rdata, 64'd0);
`ifdef DMEM_ARB_PERF_EN
        check("perf_conf_clr",  {32'd0, perf_conflicts},    64'd0);
        check("perf_stall_clr", {32'd0, perf_stall_cycles}, 64'd0);
`endif
        @(posedge clk); #1;

        for (int p = 0; p < 3; p++) begin
            run_txn("t6_pair", 2'b01, 64'h100, 64'h0, 2'b10, 64'h108, 64'(p));
        end
`ifdef DMEM_ARB_PERF_EN
        check("perf_conflicts", {32'd0, perf_conflicts},    64'd3);
        check("perf_stalls",    {32'd0, perf_stall_cycles}, 64'd6);
`endif
        go_idle();
        @(posedge clk); #1;

        // Random traffic on a small address window to force collisions
        for (int t = 0; t < 60; t++) begin
            logic [1:0]  o0, o1;
            logic [63:0] ra0, ra1, rd0, rd1;
            o0  = 2'($urandom_range(0, 3));
            o1  = 2'($urandom_range(0, 3));
            ra0 = 64'h400 + 64'(8 * $urandom_range(0, 7));
            ra1 = 64'h400 + 64'(8 * $urandom_range(0, 7));
            rd0 = {32'($urandom), 32'($urandom)};
            rd1 = {32'($urandom), 32'($urandom)};
            run_txn("rand", o0, ra0, rd0, o1, ra1, rd1);
        end
        go_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
